// File: rtl/alu_issue_stage_if.sv
// ID/EX issue bus between the decode stage (master) and the ALU issue stage (slave).
interface alu_issue_stage_if #(
    parameter int WORD_WIDTH = 32,
    parameter int REG_ADDR_W = 5
);
    logic                          id_valid;
    logic                          stall;
    logic                          flush;
    logic [1:0]                    alu_op;
    logic [5:0]                    funct;
    logic                          alu_src;
    logic                          reg_dst;
    logic [WORD_WIDTH-1:0]         rs_data;
    logic [WORD_WIDTH-1:0]         rt_data;
    logic [WORD_WIDTH-1:0]         imm_ext;
    logic [REG_ADDR_W-1:0]         rt;
    logic [REG_ADDR_W-1:0]         rd;
    logic                          ex_valid;
    logic signed [WORD_WIDTH-1:0]  ex_a;
    logic signed [WORD_WIDTH-1:0]  ex_b;
    logic [3:0]                    ex_opcode;
    logic [REG_ADDR_W-1:0]         ex_dest;
    logic                          ex_illegal;

    modport master (
        output id_valid, stall, flush, alu_op, funct, alu_src, reg_dst,
               rs_data, rt_data, imm_ext, rt, rd,
        input  ex_valid, ex_a, ex_b, ex_opcode, ex_dest, ex_illegal
    );

    modport slave (
        input  id_valid, stall, flush, alu_op, funct, alu_src, reg_dst,
               rs_data, rt_data, imm_ext, rt, rd,
        output ex_valid, ex_a, ex_b, ex_opcode, ex_dest, ex_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX stage feeding the execute ALU: opcode decode, operand/destination select, stall/flush.
// Optional SLT support is enabled by defining ALU_ISSUE_SLT_EN.
module alu_issue_stage #(
    parameter int WORD_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input logic clk,
    input logic reset,
    alu_issue_stage_if.slave bus
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;
`ifdef ALU_ISSUE_SLT_EN
    localparam logic [3:0] OP_SLT = 4'b0111;
`endif

    // Returns {illegal, opcode}; unsupported R-type functs fall back to ADD.
    function automatic logic [4:0] f_decode(input logic [1:0] op, input logic [5:0] fn);
        logic [4:0] res;
        res = {1'b0, OP_ADD};
        case (op)
            2'b00: res = {1'b0, OP_ADD};
            2'b01: res = {1'b0, OP_SUB};
            2'b11: res = {1'b0, OP_OR};
            default: begin
                case (fn)
                    6'b100000, 6'b100001: res = {1'b0, OP_ADD};
                    6'b100010, 6'b100011: res = {1'b0, OP_SUB};
                    6'b100100:            res = {1'b0, OP_AND};
                    6'b100101:            res = {1'b0, OP_OR};
                    6'b100111:            res = {1'b0, OP_NOR};
`ifdef ALU_ISSUE_SLT_EN
                    6'b101010:            res = {1'b0, OP_SLT};
`endif
                    default:              res = {1'b1, OP_ADD};
                endcase
            end
        endcase
        return res;
    endfunction

    logic [4:0]                   w_dec_p0;
    logic signed [WORD_WIDTH-1:0] w_b_p0;
    logic [REG_ADDR_W-1:0]        w_dest_p0;

    always_comb begin
        w_dec_p0  = f_decode(bus.alu_op, bus.funct);
        w_b_p0    = bus.alu_src ? bus.imm_ext : bus.rt_data;
        w_dest_p0 = bus.reg_dst ? bus.rd : bus.rt;
    end

    // ---- p0 -> p1 register boundary; initial values are the bubble ----
    logic                         r_vld_p1     = 1'b0;
    logic signed [WORD_WIDTH-1:0] r_a_p1       = '0;
    logic signed [WORD_WIDTH-1:0] r_b_p1       = '0;
    logic [3:0]                   r_opcode_p1  = OP_ADD;
    logic [REG_ADDR_W-1:0]        r_dest_p1    = '0;
    logic                         r_illegal_p1 = 1'b0;

    always_ff @(posedge clk) begin
        if (reset || bus.flush || (!bus.stall && !bus.id_valid)) begin
            r_vld_p1     <= 1'b0;
            r_a_p1       <= '0;
            r_b_p1       <= '0;
            r_opcode_p1  <= OP_ADD;
            r_dest_p1    <= '0;
            r_illegal_p1 <= 1'b0;
        end else if (!bus.stall) begin
            r_vld_p1     <= 1'b1;
            r_a_p1       <= bus.rs_data;
            r_b_p1       <= w_b_p0;
            r_opcode_p1  <= w_dec_p0[3:0];
            r_dest_p1    <= w_dest_p0;
            r_illegal_p1 <= w_dec_p0[4];
        end
    end

    assign bus.ex_valid   = r_vld_p1;
    assign bus.ex_a       = r_a_p1;
    assign bus.ex_b       = r_b_p1;
    assign bus.ex_opcode  = r_opcode_p1;
    assign bus.ex_dest    = r_dest_p1;
    assign bus.ex_illegal = r_illegal_p1;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with hand-computed expectations.
module tb_alu_issue_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_assert = 0;
    int n_fail = 0;

    alu_issue_stage_if #(.WORD_WIDTH(32), .REG_ADDR_W(5)) bus ();

    alu_issue_stage #(.WORD_WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] op,
                           input logic [4:0] dest, input logic ill);
        chk({tag, ".valid"},   {63'd0, bus.ex_valid},   {63'd0, v});
        chk({tag, ".a"},       {32'd0, bus.ex_a},       {32'd0, a});
        chk({tag, ".b"},       {32'd0, bus.ex_b},       {32'd0, b});
        chk({tag, ".opcode"},  {60'd0, bus.ex_opcode},  {60'd0, op});
        chk({tag, ".dest"},    {59'd0, bus.ex_dest},    {59'd0, dest});
        chk({tag, ".illegal"}, {63'd0, bus.ex_illegal}, {63'd0, ill});
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic src, input logic dst, input logic [31:0] rs,
                         input logic [31:0] rtd, input logic [31:0] imm,
                         input logic [4:0] rt_i, input logic [4:0] rd_i);
        bus.id_valid = v;
        bus.alu_op   = op;
        bus.funct    = fn;
        bus.alu_src  = src;
        bus.reg_dst  = dst;
        bus.rs_data  = rs;
        bus.rt_data  = rtd;
        bus.imm_ext  = imm;
        bus.rt       = rt_i;
        bus.rd       = rd_i;
    endtask

    logic [5:0] sweep_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111};
    logic [3:0] sweep_op [5] = '{4'b0010,   4'b0110,   4'b0000,   4'b0001,   4'b1100};

    initial begin
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        // Reset with random inputs
        drive(1'b1, 2'($urandom), 6'($urandom), 1'($urandom), 1'($urandom),
              $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom));
        bus.stall = 1'($urandom);
        tick();
        chk_all("reset1", 1'b0, 32'd0, 32'd0, 4'b0010, 5'd0, 1'b0);
        tick();
        chk_all("reset2", 1'b0, 32'd0, 32'd0, 4'b0010, 5'd0, 1'b0);
        reset = 1'b0;
        bus.stall = 1'b0;

        // R-type sweep
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b10, sweep_fn[i], 1'b0, 1'b1, 32'h0000_0005, 32'hFFFF_FFFD,
                  32'h0000_1234, 5'd3, 5'd9);
            tick();
            chk_all($sformatf("rtype%0d", i), 1'b1, 32'h5, 32'hFFFF_FFFD, sweep_op[i], 5'd9, 1'b0);
        end
        drive(1'b1, 2'b10, 6'b100001, 1'b0, 1'b1, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2);
        tick();
        chk_all("addu", 1'b1, 32'h1, 32'h2, 4'b0010, 5'd2, 1'b0);
        drive(1'b1, 2'b10, 6'b100011, 1'b0, 1'b1, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2);
        tick();
        chk_all("subu", 1'b1, 32'h1, 32'h2, 4'b0110, 5'd2, 1'b0);

        // Immediate path
        drive(1'b1, 2'b00, 6'b101010, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0777,
              32'hFFFF_FFF0, 5'd4, 5'd12);
        tick();
        chk_all("imm", 1'b1, 32'h100, 32'hFFFF_FFF0, 4'b0010, 5'd4, 1'b0);

        // beq and ori decode, illegal forced low for non-R-type
        drive(1'b1, 2'b11, 6'b000000, 1'b1, 1'b0, 32'hA, 32'hB, 32'hC, 5'd6, 5'd7);
        tick();
        chk_all("ori", 1'b1, 32'hA, 32'hC, 4'b0001, 5'd6, 1'b0);

        // Load, then stall 3 cycles while inputs change
        drive(1'b1, 2'b01, 6'b000000, 1'b0, 1'b1, 32'h11, 32'h22, 32'h33, 5'd5, 5'd7);
        tick();
        chk_all("beq", 1'b1, 32'h11, 32'h22, 4'b0110, 5'd7, 1'b0);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(i[0], 2'b10, 6'b100111, 1'b1, 1'b0, 32'h99 + i, 32'h88, 32'h77, 5'd20, 5'd21);
            tick();
            chk_all($sformatf("stall%0d", i), 1'b1, 32'h11, 32'h22, 4'b0110, 5'd7, 1'b0);
        end
        bus.flush = 1'b1;
        tick();
        chk_all("stallflush", 1'b0, 32'd0, 32'd0, 4'b0010, 5'd0, 1'b0);
        bus.flush = 1'b0;
        bus.stall = 1'b0;

        // id_valid low loads a bubble
        drive(1'b0, 2'b10, 6'b100100, 1'b0, 1'b1, 32'h5, 32'h6, 32'h7, 5'd8, 5'd9);
        tick();
        chk_all("novalid", 1'b0, 32'd0, 32'd0, 4'b0010, 5'd0, 1'b0);

        // Illegal funct and SLT
        drive(1'b1, 2'b10, 6'b000000, 1'b0, 1'b1, 32'h5, 32'h6, 32'h7, 5'd8, 5'd9);
        tick();
        chk_all("illegal", 1'b1, 32'h5, 32'h6, 4'b0010, 5'd9, 1'b1);
        drive(1'b1, 2'b10, 6'b101010, 1'b0, 1'b1, 32'h5, 32'h6, 32'h7, 5'd8, 5'd9);
        tick();
`ifdef ALU_ISSUE_SLT_EN
        chk_all("slt", 1'b1, 32'h5, 32'h6, 4'b0111, 5'd9, 1'b0);
`else
        chk_all("slt", 1'b1, 32'h5, 32'h6, 4'b0010, 5'd9, 1'b1);
`endif

        // Mid-stall reset
        drive(1'b1, 2'b00, 6'b000000, 1'b0, 1'b0, 32'h55, 32'h66, 32'h0, 5'd2, 5'd3);
        tick();
        chk_all("preload", 1'b1, 32'h55, 32'h66, 4'b0010, 5'd2, 1'b0);
        bus.stall = 1'b1;
        drive(1'b1, 2'b01, 6'b000000, 1'b0, 1'b1, 32'h77, 32'h88, 32'h0, 5'd10, 5'd11);
        tick();
        chk_all("held", 1'b1, 32'h55, 32'h66, 4'b0010, 5'd2, 1'b0);
        reset = 1'b1;
        tick();
        chk_all("midreset", 1'b0, 32'd0, 32'd0, 4'b0010, 5'd0, 1'b0);
        reset = 1'b0;
        bus.stall = 1'b0;
        tick();
        chk_all("afterreset", 1'b1, 32'h77, 32'h88, 4'b0110, 5'd11, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
